// File: rtl/drive_pkg.sv
// Shared encodings for the drive command scheduler.
// Mode codes, the STOP byte, the command prefix and the command bit map.
package drive_pkg;

    typedef enum logic [1:0] {
        MODE_NONE   = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_SEMI   = 2'b10,
        MODE_AUTO   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

    localparam logic [7:0] STOP_BYTE  = 8'h80;
    localparam logic [1:0] CMD_PREFIX = 2'b10;

    localparam int BIT_FWD     = 0;
    localparam int BIT_BACK    = 1;
    localparam int BIT_LEFT    = 2;
    localparam int BIT_RIGHT   = 3;
    localparam int BIT_PLACE   = 4;
    localparam int BIT_DESTROY = 5;

    function automatic logic prefix_ok(input logic [7:0] b);
        return b[7:6] == CMD_PREFIX;
    endfunction

endpackage

// File: rtl/drive_cmd_scheduler_refresh.sv
// Idle-time counter that flags when the last command must be re-sent.
// Saturates at its terminal count so a pending refresh is never lost.
module cmd_refresh_timer #(
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(REFRESH_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expire_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/drive_cmd_scheduler.sv
// Arbitrates the driving-mode sources onto the UART TX byte stream,
// inserting STOP on mode change / power-off and refreshing when idle.
module drive_cmd_scheduler
    import drive_pkg::*;
#(
    parameter int REFRESH_CYCLES = 1000000,
    parameter int GAP_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        power_on,
    input  logic [1:0]  mode_sel,
    input  logic [2:0]  src_valid,
    input  logic [23:0] src_cmd,
    output logic [2:0]  src_ack,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [1:0]  active_mode,
    output logic        cmd_err
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_e        state_q;
    mode_e         active_mode_q;
    mode_e         eff_mode;
    logic          power_q;
    logic          stop_pending_q;
    logic          stop_req;
    logic          tx_valid_q;
    logic [7:0]    tx_data_q;
    logic [7:0]    last_sent_q;
    logic [2:0]    src_ack_q;
    logic          cmd_err_q;
    logic [GW-1:0] gap_q;
    logic          sel_valid;
    logic [7:0]    sel_cmd;
    logic [2:0]    sel_ack;
    logic          refresh_due;
    logic          accept;

    assign eff_mode = power_on ? mode_e'(mode_sel) : MODE_NONE;
    assign stop_req = stop_pending_q
                    | (eff_mode != active_mode_q)
                    | (power_q & ~power_on);
    assign accept   = (state_q == ST_SEND) & tx_ready;

    // Only the mode that currently owns the link is looked at.
    always_comb begin
        sel_valid = 1'b0;
        sel_cmd   = STOP_BYTE;
        sel_ack   = 3'b000;
        case (active_mode_q)
            MODE_MANUAL: begin
                sel_valid = src_valid[0];
                sel_cmd   = src_cmd[7:0];
                sel_ack   = 3'b001;
            end
            MODE_SEMI: begin
                sel_valid = src_valid[1];
                sel_cmd   = src_cmd[15:8];
                sel_ack   = 3'b010;
            end
            MODE_AUTO: begin
                sel_valid = src_valid[2];
                sel_cmd   = src_cmd[23:16];
                sel_ack   = 3'b100;
            end
            default: ;
        endcase
    end

    cmd_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (state_q == ST_IDLE),
        .clr_i   (accept),
        .expire_o(refresh_due)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            active_mode_q  <= MODE_NONE;
            power_q        <= 1'b0;
            stop_pending_q <= 1'b0;
            tx_valid_q     <= 1'b0;
            tx_data_q      <= STOP_BYTE;
            last_sent_q    <= STOP_BYTE;
            src_ack_q      <= 3'b000;
            cmd_err_q      <= 1'b0;
            gap_q          <= '0;
        end else begin
            power_q        <= power_on;
            stop_pending_q <= stop_req;
            src_ack_q      <= 3'b000;
            case (state_q)
                ST_IDLE: begin
                    if (stop_req) begin
                        tx_data_q      <= STOP_BYTE;
                        tx_valid_q     <= 1'b1;
                        active_mode_q  <= eff_mode;
                        stop_pending_q <= 1'b0;
                        state_q        <= ST_SEND;
                    end else if (active_mode_q != MODE_NONE && sel_valid) begin
                        src_ack_q <= sel_ack;
                        if (!prefix_ok(sel_cmd)) begin
                            cmd_err_q  <= 1'b1;
                            tx_data_q  <= STOP_BYTE;
                            tx_valid_q <= 1'b1;
                            state_q    <= ST_SEND;
                        end else if (sel_cmd != last_sent_q) begin
                            tx_data_q  <= sel_cmd;
                            tx_valid_q <= 1'b1;
                            state_q    <= ST_SEND;
                        end
                    end else if (refresh_due) begin
                        tx_data_q  <= last_sent_q;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_valid_q  <= 1'b0;
                        last_sent_q <= tx_data_q;
                        gap_q       <= '0;
                        state_q     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign src_ack     = src_ack_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign active_mode = active_mode_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: doc/drive_cmd_scheduler.md
Name: drive_cmd_scheduler

Overview:
- Sequences command bytes for the car simulator onto the single UART transmitter.
- Arbitrates between three driving-mode sources: manual, semi-auto and auto. Only the currently selected mode owns the link.
- Inserts a STOP byte on every mode change and on power-off.
- Periodically re-sends the last command so the simulator never loses its state.
- Sits between the mode controllers and the UART TX byte interface.

Parameters:
- REFRESH_CYCLES, 1000000: idle cycles before the last command is re-sent (10 ms at 100 MHz).
- GAP_CYCLES, 16: minimum idle cycles between two transmitted bytes.
- STOP_BYTE, 8'h80: prefix 2'b10, all movement and barrier bits zero.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous, active-low reset
- power_on  in  1  1 = car powered; 0 forces STOP-only operation
- mode_sel  in  2  00 none, 01 manual, 10 semi-auto, 11 auto
- src_valid  in  3  per-source byte valid; bit0 manual, bit1 semi, bit2 auto
- src_cmd  in  24  per-source command byte; [7:0] manual, [15:8] semi, [23:16] auto
- src_ack  out  3  one-cycle pulse: the selected source's byte was consumed
- tx_valid  out  1  byte available to the UART TX
- tx_data  out  8  byte to transmit
- tx_ready  in  1  UART TX accepts tx_data this cycle
- active_mode  out  2  mode currently owning the link
- cmd_err  out  1  sticky flag: a byte with a bad prefix was received

Behaviour:
- Reset (rst=0, asynchronous) sets: state IDLE, tx_valid 0, tx_data STOP_BYTE, last_sent STOP_BYTE, active_mode 00, src_ack 0, cmd_err 0, refresh and gap counters 0, stop_pending 0.
- eff_mode = power_on ? mode_sel : 00.
- stop_pending is set when eff_mode differs from active_mode, or on the falling edge of power_on. It is cleared when STOP is loaded.
- FSM states:
  - IDLE: tx_valid=0; refresh counter increments. Priority of next action:
    1. stop_pending: load STOP_BYTE, set active_mode <= eff_mode, go to SEND.
    2. active_mode != 00, src_valid of the selected source = 1, and byte != last_sent: load the byte, pulse src_ack, go to SEND.
    3. Same as 2 but byte == last_sent: pulse src_ack, drop the byte, stay in IDLE.
    4. Refresh counter == REFRESH_CYCLES-1: reload last_sent, go to SEND.
  - SEND: tx_valid=1; tx_data and tx_valid are held stable until tx_ready=1 is sampled. On the accepting edge: last_sent <= tx_data, refresh counter <= 0, go to GAP.
  - GAP: tx_valid=0. Count GAP_CYCLES, then go to IDLE. Source bytes are not consumed in GAP.
- Latency: a source byte latched in IDLE appears as tx_valid=1 on the next cycle.
- Non-selected sources never receive src_ack; their valid is ignored and is neither dropped nor queued.
- Prefix check: a selected byte with [7:6] != 2'b10 is acked, replaced by STOP_BYTE, and sets cmd_err. cmd_err is cleared only by reset.
- A mode change during SEND or GAP does not abort the byte in flight. STOP is sent at the next IDLE.
- With power_on=0, only STOP_BYTE is ever sent: once on the falling edge, then on every refresh.
- Simultaneous stop_pending and refresh expiry: STOP wins and the refresh counter restarts after it.
- Counter widths: $clog2(REFRESH_CYCLES) and $clog2(GAP_CYCLES+1). The refresh counter saturates and does not wrap while a send is pending.
- A reset asserted mid-SEND drops tx_valid immediately (asynchronous).

Decomposition:
- Shared package drive_pkg holds:
  - mode encodings MODE_NONE, MODE_MANUAL, MODE_SEMI, MODE_AUTO;
  - STOP_BYTE;
  - CMD_PREFIX (2'b10);
  - command bit positions: fwd 0, back 1, left 2, right 3, place 4, destroy 5.
- One natural sub-module, cmd_refresh_timer: refresh counter with clear and expire outputs. Everything else stays inline.

Test Plan (bench overrides REFRESH_CYCLES=100, GAP_CYCLES=4; tx_ready tied 1 unless stated):
- Reset release, power_on=1, mode_sel=01 -> STOP (8'h80) sent once, active_mode=01; no other byte until cycle 100, then 8'h80 refreshed.
- Manual src_valid with 8'h81 -> src_ack[0] pulse, tx_data=8'h81 next cycle; same byte presented again -> acked, nothing sent.
- mode_sel 01->11 while sending 8'h81 with tx_ready held 0 for 5 cycles -> 8'h81 held stable and completes, then 8'h80 sent, active_mode=11; manual valid ignored (src_ack[0]=0).
- Auto sends 8'h3F (bad prefix) -> src_ack[2] pulse, 8'h80 sent, cmd_err=1 and stays 1.
- power_on 1->0 -> 8'h80 sent, active_mode=00, all src_ack stay 0; 8'h80 repeats every 100+ idle cycles.
- Assert rst during SEND -> tx_valid=0 in the same cycle, all outputs at reset values.
